// File: rtl/fetch_pkg.sv
// Shared fetch-path types: instruction/PC widths and the queue entry layout.
// Used by the cache fetch stage, the fetch queue and decode.
package fetch_pkg;

  localparam int FETCH_WIDTH = 4;
  localparam int INST_W      = 32;
  localparam int PC_W        = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// Fetch queue storage: DEPTH entries, four independent write ports
// (distinct indices within a cycle), two combinational read ports.
module fetchq_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic [FETCH_WIDTH-1:0]                wr_en,
  input  logic [FETCH_WIDTH-1:0][AW-1:0]        wr_idx,
  input  fq_entry_t [FETCH_WIDTH-1:0]           wr_data,
  input  logic [AW-1:0]                         rd_idx0,
  input  logic [AW-1:0]                         rd_idx1,
  output fq_entry_t                             rd_data0,
  output fq_entry_t                             rd_data1
);

  fq_entry_t mem [DEPTH];

  // Write every enabled port; the queue never drives two ports to one index.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (wr_en[k]) mem[wr_idx[k]] <= wr_data[k];
    end
  end

  assign rd_data0 = mem[rd_idx0];
  assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the I-cache and decode.
// Optional feature macro: FETCHQ_BYPASS_EN (0-cycle latency on an empty queue).
//
// Handshakes:
//   fetch side : a group is taken at the rising edge when in_valid & in_ready
//                & ~flush; in_ready depends only on registered occupancy and
//                never on in_valid; a group is taken whole or not at all.
//   decode side: outN_valid marks a presented entry; deq_cnt says how many of
//                the presented entries decode takes at this edge (clamped to
//                the number valid, 3 treated as 2).
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DEQ_MAX = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              fetch_pc,
  input  logic [32:0]              inst0,
  input  logic [32:0]              inst1,
  input  logic [32:0]              inst2,
  input  logic [32:0]              inst3,
  output logic                     out0_valid,
  output logic                     out1_valid,
  output logic [31:0]              out0_pc,
  output logic [31:0]              out1_pc,
  output logic [31:0]              out0_inst,
  output logic [31:0]              out1_inst,
  input  logic [1:0]               deq_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = 3;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;

  logic [FETCH_WIDTH-1:0]             slot_v;
  logic [FETCH_WIDTH-1:0][INST_W-1:0] slot_inst;
  logic [NW-1:0] n_enq, n_deq, skip, wr_cnt, deq_q;
  logic [1:0]    deq_req;
  logic          enq_fire, byp;

  logic [FETCH_WIDTH-1:0]         wr_en;
  logic [FETCH_WIDTH-1:0][AW-1:0] wr_idx;
  fq_entry_t [FETCH_WIDTH-1:0]    wr_data;
  fq_entry_t                      rd_data0, rd_data1;

  assign slot_v    = {inst3[32], inst2[32], inst1[32], inst0[32]};
  assign slot_inst = {inst3[31:0], inst2[31:0], inst1[31:0], inst0[31:0]};

  assign count    = count_q;
  assign in_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));
  assign enq_fire = in_valid & in_ready & ~flush;
  assign deq_req  = (deq_cnt > 2'(DEQ_MAX)) ? 2'(DEQ_MAX) : deq_cnt;

`ifdef FETCHQ_BYPASS_EN
  assign byp = (count_q == '0) & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  // Length of the leading valid prefix: the lowest invalid slot index wins.
  always_comb begin
    n_enq = NW'(FETCH_WIDTH);
    for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
      if (!slot_v[k]) n_enq = NW'(k);
    end
  end

  // Present head/head+1 from storage, or the incoming group when bypassing.
  always_comb begin
    out0_valid = (count_q >= CW'(1));
    out1_valid = (count_q >= CW'(2));
    out0_pc    = out0_valid ? rd_data0.pc   : '0;
    out0_inst  = out0_valid ? rd_data0.inst : '0;
    out1_pc    = out1_valid ? rd_data1.pc   : '0;
    out1_inst  = out1_valid ? rd_data1.inst : '0;
    if (byp) begin
      out0_valid = (n_enq >= NW'(1));
      out1_valid = (n_enq >= NW'(2));
      out0_pc    = out0_valid ? fetch_pc           : '0;
      out0_inst  = out0_valid ? slot_inst[0]       : '0;
      out1_pc    = out1_valid ? fetch_pc + 32'd4   : '0;
      out1_inst  = out1_valid ? slot_inst[1]       : '0;
    end
  end

  // Dequeue amount clamped to presented entries; bypassed slots are skipped on write.
  always_comb begin
    n_deq = '0;
    if (out0_valid && deq_req >= 2'd1) n_deq = NW'(1);
    if (out1_valid && deq_req >= 2'd2) n_deq = NW'(2);
    skip   = byp ? n_deq : '0;
    deq_q  = byp ? '0 : n_deq;
    wr_cnt = enq_fire ? (n_enq - skip) : '0;
  end

  // Map accepted slots onto the write ports at consecutive queue indices.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_en[k]        = enq_fire && (NW'(k) >= skip) && (NW'(k) < n_enq);
      wr_idx[k]       = wr_ptr + AW'(k) - AW'(skip);
      wr_data[k].pc   = fetch_pc + 32'(4 * k);
      wr_data[k].inst = slot_inst[k];
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + AW'(deq_q);
      wr_ptr  <= wr_ptr + AW'(wr_cnt);
      count_q <= count_q + CW'(wr_cnt) - CW'(deq_q);
    end
  end

  fetchq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_idx0  (rd_ptr),
    .rd_idx1  (rd_ptr + AW'(1)),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios with literal expectations
// plus a randomized phase, all checked against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fetch_pc = '0;
  logic [32:0] inst0 = '0, inst1 = '0, inst2 = '0, inst3 = '0;
  logic        out0_valid, out1_valid;
  logic [31:0] out0_pc, out1_pc, out0_inst, out1_inst;
  logic [1:0]  deq_cnt = '0;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] wrap_pcs[$];
  logic        wrap_mode = 1'b0;

  inst_fetch_queue #(.DEPTH(DEPTH), .DEQ_MAX(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .fetch_pc(fetch_pc),
    .inst0(inst0), .inst1(inst1), .inst2(inst2), .inst3(inst3),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_pc(out0_pc), .out1_pc(out1_pc),
    .out0_inst(out0_inst), .out1_inst(out1_inst),
    .deq_cnt(deq_cnt), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prefix_len(input logic [3:0] v);
    int n;
    n = 0;
    while (n < 4 && v[n]) n++;
    return n;
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    deq_cnt  = 2'd0;
    #1;
  endtask

  task automatic drive_group(input logic [31:0] pc, input logic [3:0] vbits, input logic [1:0] deq);
    in_valid = 1'b1;
    fetch_pc = pc;
    inst0    = {vbits[0], $urandom()};
    inst1    = {vbits[1], $urandom()};
    inst2    = {vbits[2], $urandom()};
    inst3    = {vbits[3], $urandom()};
    deq_cnt  = deq;
  endtask

  // scoreboard: reference queue compared every cycle, then advanced by this cycle's inputs
  always @(negedge clk) begin
    int sz, ne, nd, avail, want;
    logic [31:0] insts [4];
    logic [63:0] e0, e1;
    logic v0, v1, byp;
    if (reset) begin
      exp_q.delete();
    end else begin
      insts[0] = inst0[31:0]; insts[1] = inst1[31:0];
      insts[2] = inst2[31:0]; insts[3] = inst3[31:0];
      ne  = prefix_len({inst3[32], inst2[32], inst1[32], inst0[32]});
      sz  = exp_q.size();
      byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      if (sz == 0 && in_valid && !flush) begin
        byp = 1'b1;
        for (int k = 0; k < ne; k++) exp_q.push_back({fetch_pc + 32'(4 * k), insts[k]});
      end
`endif
      v0 = exp_q.size() >= 1;
      v1 = exp_q.size() >= 2;
      e0 = v0 ? exp_q[0] : 64'd0;
      e1 = v1 ? exp_q[1] : 64'd0;
      check("m_count", 64'(count), 64'(sz));
      check("m_in_ready", 64'(in_ready), 64'((DEPTH - sz) >= 4));
      check("m_out0_valid", 64'(out0_valid), 64'(v0));
      check("m_out1_valid", 64'(out1_valid), 64'(v1));
      check("m_out0", {out0_pc, out0_inst}, e0);
      check("m_out1", {out1_pc, out1_inst}, e1);
      if (flush) begin
        exp_q.delete();
      end else begin
        want  = (deq_cnt == 2'd3) ? 2 : int'(deq_cnt);
        avail = int'(v0) + int'(v1);
        nd    = (want < avail) ? want : avail;
        if (wrap_mode && nd >= 1) wrap_pcs.push_back(out0_pc);
        if (wrap_mode && nd >= 2) wrap_pcs.push_back(out1_pc);
        for (int k = 0; k < nd; k++) void'(exp_q.pop_front());
        if (!byp && in_valid && (DEPTH - sz) >= 4)
          for (int k = 0; k < ne; k++) exp_q.push_back({fetch_pc + 32'(4 * k), insts[k]});
      end
    end
  end

  initial begin
    logic [31:0] saved0;
    logic        acc;
    int          g, guard, r;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_valids", 64'({out0_valid, out1_valid}), 64'd0);
    check("rst_outs", {out0_pc, out0_inst, out1_pc, out1_inst}, 128'd0);

    // four valid slots
    drive_group(32'h1000, 4'hF, 2'd0);
    saved0 = inst0[31:0];
    cycle();
    check("t1_count", 64'(count), 64'd4);
    check("t1_out0_pc", 64'(out0_pc), 64'h1000);
    check("t1_out1_pc", 64'(out1_pc), 64'h1004);
    check("t1_out0_inst", 64'(out0_inst), 64'(saved0));
    flush = 1'b1;
    cycle();
    check("t1_flush_count", 64'(count), 64'd0);

    // hole at slot 2 drops slot 3
    drive_group(32'h2000, 4'b1011, 2'd0);
    cycle();
    check("t2_count", 64'(count), 64'd2);
    check("t2_out1_pc", 64'(out1_pc), 64'h2004);
    deq_cnt = 2'd2;
    cycle();
    check("t2_drain", 64'(count), 64'd0);
    check("t2_drain_v0", 64'(out0_valid), 64'd0);

    // fill to full, overflow attempt, drain back
    for (int k = 0; k < 3; k++) begin
      drive_group(32'h3000 + 32'(16 * k), 4'hF, 2'd0);
      cycle();
    end
    check("t3_count12", 64'(count), 64'd12);
    check("t3_ready12", 64'(in_ready), 64'd1);
    drive_group(32'h3030, 4'hF, 2'd0);
    cycle();
    check("t3_count16", 64'(count), 64'd16);
    check("t3_ready16", 64'(in_ready), 64'd0);
    drive_group(32'h4000, 4'hF, 2'd0);
    cycle();
    check("t3_ignored", 64'(count), 64'd16);
    deq_cnt = 2'd2; cycle();
    deq_cnt = 2'd3; cycle();
    check("t3_count_back", 64'(count), 64'd12);
    check("t3_ready_back", 64'(in_ready), 64'd1);
    check("t3_head", 64'(out0_pc), 64'h3010);
    deq_cnt = 2'd2; cycle();
    deq_cnt = 2'd1; cycle();
    check("t3_count9", 64'(count), 64'd9);

    // flush at 9 with simultaneous enqueue/dequeue
    drive_group(32'h4100, 4'hF, 2'd2);
    flush = 1'b1;
    cycle();
    check("t4_count", 64'(count), 64'd0);
    check("t4_ready", 64'(in_ready), 64'd1);
    check("t4_outs", {31'd0, out0_valid, out0_pc, out0_inst}, 96'd0);

    // single entry, over-asked dequeue
    drive_group(32'h5000, 4'b0001, 2'd0);
    cycle();
    check("t5_count1", 64'(count), 64'd1);
    deq_cnt = 2'd2;
    cycle();
    check("t5_count0", 64'(count), 64'd0);
    check("t5_v0", 64'(out0_valid), 64'd0);

    // wrap-around: 20 groups with steady two-wide decode
    wrap_mode = 1'b1;
    g = 0; guard = 0;
    while (g < 20 && guard < 200) begin
      acc = in_ready;
      drive_group(32'h1000 + 32'(16 * g), 4'hF, 2'd2);
      cycle();
      if (acc) g++;
      guard++;
    end
    check("wrap_timeout", 64'(guard < 200), 64'd1);
    guard = 0;
    while (count != '0 && guard < 100) begin
      deq_cnt = 2'd2;
      cycle();
      guard++;
    end
    wrap_mode = 1'b0;
    check("wrap_drain", 64'(count), 64'd0);
    check("wrap_len", 64'(wrap_pcs.size()), 64'd80);
    for (int i = 0; i < wrap_pcs.size() && i < 80; i++)
      check("wrap_pc", 64'(wrap_pcs[i]), 64'(32'h1000 + 32'(4 * i)));

`ifdef FETCHQ_BYPASS_EN
    // empty queue: group visible the same cycle, two consumed immediately
    drive_group(32'h6000, 4'hF, 2'd2);
    saved0 = inst0[31:0];
    #1;
    check("byp_v", 64'({out0_valid, out1_valid}), 64'd3);
    check("byp_pc0", 64'(out0_pc), 64'h6000);
    check("byp_pc1", 64'(out1_pc), 64'h6004);
    check("byp_inst0", 64'(out0_inst), 64'(saved0));
    cycle();
    check("byp_count", 64'(count), 64'd2);
    check("byp_head", 64'(out0_pc), 64'h6008);
    flush = 1'b1;
    cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) < 7)
        drive_group(($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC),
                    ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
      else
        deq_cnt = 2'($urandom_range(0, 3));
      flush = (r < 3);
      reset = (r == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
